// File: rtl/snake_pkg.sv
// Shared direction encoding and helpers for the snake game datapath.
package snake_pkg;

  localparam int DIR_W = 2;

  localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd1;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd2;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd3;

  // Opposite directions differ only in the low bit.
  function automatic logic [DIR_W-1:0] dir_opp(input logic [DIR_W-1:0] d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Circular direction buffer with registered count/full/empty and same-cycle read+write.
module dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [DIR_W-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [DIR_W-1:0] rd_data_o,
  output logic [PTR_W:0]   cnt_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DIR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             wr_ok, rd_ok;

  always_comb begin
    rd_ok    = rd_en_i && !empty_q;
    // A pop in the same cycle frees the slot a full-queue write needs.
    wr_ok    = wr_en_i && (!full_q || rd_ok);
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == FULL_CNT);
      empty_q  <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign cnt_o     = cnt_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/dir_cmd_queue.sv
// Buffers direction keys and commits one per game step. Define DIR_REV_FILTER_EN
// to reject duplicate and 180-degree reversal keys before they are queued.
module dir_cmd_queue
  import snake_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter int               PTR_W    = 2,
  parameter logic [DIR_W-1:0] DIR_INIT = 2'd3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIR_W-1:0] dir_in,
  input  logic             dir_vld_in,
  input  logic             mv_in,
  input  logic             clr_in,
  output logic [DIR_W-1:0] dir_out,
  output logic             dir_chg_out,
  output logic [PTR_W:0]   cnt_out,
  output logic             empty_out,
  output logic             full_out,
  output logic             drop_out
);

  logic [DIR_W-1:0] dir_q;
  logic             chg_q, drop_q;
  logic [DIR_W-1:0] head_dir;
  logic             fifo_full, fifo_empty;
  logic             legal, push, pop, reject;

`ifdef DIR_REV_FILTER_EN
  logic [DIR_W-1:0] tail_q;
  logic [DIR_W-1:0] ref_dir;

  // Last accepted key; only meaningful while the queue holds entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tail_q <= DIR_INIT;
    else if (push) tail_q <= dir_in;
  end

  assign ref_dir = fifo_empty ? dir_q : tail_q;
`endif

  always_comb begin
    legal = 1'b1;
`ifdef DIR_REV_FILTER_EN
    legal = (dir_in != ref_dir) && (dir_in != dir_opp(ref_dir));
`endif
    pop    = mv_in && !fifo_empty && !clr_in;
    push   = dir_vld_in && !clr_in && legal && (!fifo_full || mv_in);
    reject = dir_vld_in && !clr_in && !push;
  end

  dir_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr_in),
    .wr_en_i   (push),
    .wr_data_i (dir_in),
    .rd_en_i   (pop),
    .rd_data_o (head_dir),
    .cnt_o     (cnt_out),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q  <= DIR_INIT;
      chg_q  <= 1'b0;
      drop_q <= 1'b0;
    end else if (clr_in) begin
      dir_q  <= DIR_INIT;
      chg_q  <= (dir_q != DIR_INIT);
      drop_q <= 1'b0;
    end else begin
      chg_q  <= pop && (head_dir != dir_q);
      drop_q <= reject;
      if (pop) dir_q <= head_dir;
    end
  end

  assign dir_out     = dir_q;
  assign dir_chg_out = chg_q;
  assign drop_out    = drop_q;
  assign empty_out   = fifo_empty;
  assign full_out    = fifo_full;

endmodule

// File: tb/tb_dir_cmd_queue.sv
// Randomized and directed checks of dir_cmd_queue against a queue-based reference model.
module tb_dir_cmd_queue;

`ifdef DIR_REV_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] dir_in;
  logic       dir_vld_in;
  logic       mv_in;
  logic       clr_in;
  logic [1:0] dir_out;
  logic       dir_chg_out;
  logic [2:0] cnt_out;
  logic       empty_out;
  logic       full_out;
  logic       drop_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [1:0] exp_q[$];
  logic [1:0] m_dir;
  logic       exp_chg;
  logic       exp_drop;

  dir_cmd_queue #(.DEPTH(4), .PTR_W(2), .DIR_INIT(2'd3)) dut (
    .clk         (clk),
    .rst         (rst),
    .dir_in      (dir_in),
    .dir_vld_in  (dir_vld_in),
    .mv_in       (mv_in),
    .clr_in      (clr_in),
    .dir_out     (dir_out),
    .dir_chg_out (dir_chg_out),
    .cnt_out     (cnt_out),
    .empty_out   (empty_out),
    .full_out    (full_out),
    .drop_out    (drop_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: apply one cycle of inputs using queue semantics.
  task automatic model_apply(input bit vld, input logic [1:0] d, input bit mv, input bit clr);
    logic [1:0] r;
    logic [1:0] h;
    bit ok;
    exp_chg  = 1'b0;
    exp_drop = 1'b0;
    if (clr) begin
      exp_chg = (m_dir != 2'd3);
      m_dir   = 2'd3;
      exp_q.delete();
    end else begin
      r  = (exp_q.size() > 0) ? exp_q[$] : m_dir;
      ok = vld && (exp_q.size() < 4 || mv);
      if (FILTER) ok = ok && (d != r) && (d != (r ^ 2'b01));
      exp_drop = vld && !ok;
      if (mv && exp_q.size() > 0) begin
        h       = exp_q.pop_front();
        exp_chg = (h != m_dir);
        m_dir   = h;
      end
      if (ok) exp_q.push_back(d);
    end
  endtask

  // Driver tasks
  task automatic step(input bit vld, input logic [1:0] d, input bit mv, input bit clr);
    dir_vld_in = vld;
    dir_in     = d;
    mv_in      = mv;
    clr_in     = clr;
    model_apply(vld, d, mv, clr);
    @(posedge clk);
    #1;
    dir_vld_in = 1'b0;
    mv_in      = 1'b0;
    clr_in     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dir_vld_in = 1'b0; mv_in = 1'b0; clr_in = 1'b0; dir_in = 2'd0;
    exp_q.delete();
    m_dir = 2'd3; exp_chg = 1'b0; exp_drop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dir_out !== 2'd3) begin errors++; $display("FAIL reset_dir got %0d exp 3", dir_out); end
    checks++; if (cnt_out !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt_out); end
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty_out); end
    checks++; if (full_out !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", full_out); end
    checks++; if (dir_chg_out !== 1'b0 || drop_out !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got chg=%0b drop=%0b exp 0/0", dir_chg_out, drop_out);
    end
    step(1'b0, 2'd0, 1'b1, 1'b0);
    checks++; if (dir_out !== 2'd3 || dir_chg_out !== 1'b0) begin
      errors++; $display("FAIL empty_mv got dir=%0d chg=%0b exp 3/0", dir_out, dir_chg_out);
    end
  endtask

  task automatic test_single_pop();
    do_reset();
    step(1'b1, 2'd0, 1'b0, 1'b0);
    checks++; if (cnt_out !== 3'd1) begin errors++; $display("FAIL push_up_cnt got %0d exp 1", cnt_out); end
    step(1'b0, 2'd0, 1'b1, 1'b0);
    checks++; if (dir_out !== 2'd0 || dir_chg_out !== 1'b1 || cnt_out !== 3'd0) begin
      errors++; $display("FAIL pop_up got dir=%0d chg=%0b cnt=%0d exp 0/1/0", dir_out, dir_chg_out, cnt_out);
    end
    step(1'b0, 2'd0, 1'b0, 1'b0);
    checks++; if (dir_chg_out !== 1'b0) begin errors++; $display("FAIL chg_one_cycle got %0b exp 0", dir_chg_out); end
  endtask

  task automatic test_filter();
    logic exp_d;
    logic [2:0] exp_c;
    do_reset();
    exp_d = FILTER;
    exp_c = FILTER ? 3'd0 : 3'd1;
    step(1'b1, 2'd2, 1'b0, 1'b0);
    checks++; if (drop_out !== exp_d || cnt_out !== exp_c) begin
      errors++; $display("FAIL reversal got drop=%0b cnt=%0d exp %0b/%0d", drop_out, cnt_out, exp_d, exp_c);
    end
    do_reset();
    step(1'b1, 2'd3, 1'b0, 1'b0);
    checks++; if (drop_out !== exp_d || cnt_out !== exp_c) begin
      errors++; $display("FAIL duplicate got drop=%0b cnt=%0d exp %0b/%0d", drop_out, cnt_out, exp_d, exp_c);
    end
  endtask

  task automatic test_fill_drain();
    logic [1:0] seq [4];
    seq[0] = 2'd0; seq[1] = 2'd2; seq[2] = 2'd1; seq[3] = 2'd3;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, seq[i], 1'b0, 1'b0);
    checks++; if (full_out !== 1'b1 || cnt_out !== 3'd4) begin
      errors++; $display("FAIL fill got full=%0b cnt=%0d exp 1/4", full_out, cnt_out);
    end
    step(1'b1, 2'd2, 1'b0, 1'b0);
    checks++; if (drop_out !== 1'b1 || cnt_out !== 3'd4) begin
      errors++; $display("FAIL overflow got drop=%0b cnt=%0d exp 1/4", drop_out, cnt_out);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'd0, 1'b1, 1'b0);
      checks++; if (dir_out !== seq[i] || dir_chg_out !== 1'b1) begin
        errors++; $display("FAIL drain_%0d got dir=%0d chg=%0b exp %0d/1", i, dir_out, dir_chg_out, seq[i]);
      end
    end
    checks++; if (empty_out !== 1'b1 || cnt_out !== 3'd0) begin
      errors++; $display("FAIL drained got empty=%0b cnt=%0d exp 1/0", empty_out, cnt_out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b1, 1'b0);
    checks++; if (dir_out !== 2'd0 || drop_out !== 1'b0 || cnt_out !== 3'd4 || full_out !== 1'b1) begin
      errors++; $display("FAIL full_push_pop got dir=%0d drop=%0b cnt=%0d full=%0b exp 0/0/4/1",
                         dir_out, drop_out, cnt_out, full_out);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b1, 1'b0);
    checks++; if (dir_out !== 2'd0 || empty_out !== 1'b1) begin
      errors++; $display("FAIL wrap_tail got dir=%0d empty=%0b exp 0/1", dir_out, empty_out);
    end
  endtask

  task automatic test_clear();
    do_reset();
    step(1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    checks++; if (cnt_out !== 3'd2 || dir_out !== 2'd0) begin
      errors++; $display("FAIL pre_clear got cnt=%0d dir=%0d exp 2/0", cnt_out, dir_out);
    end
    step(1'b1, 2'd1, 1'b0, 1'b1);
    checks++; if (cnt_out !== 3'd0 || dir_out !== 2'd3 || dir_chg_out !== 1'b1 || drop_out !== 1'b0) begin
      errors++; $display("FAIL clear got cnt=%0d dir=%0d chg=%0b drop=%0b exp 0/3/1/0",
                         cnt_out, dir_out, dir_chg_out, drop_out);
    end
    step(1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++; if (dir_out !== 2'd3 || cnt_out !== 3'd0 || empty_out !== 1'b1 || full_out !== 1'b0 ||
                  dir_chg_out !== 1'b0 || drop_out !== 1'b0) begin
      errors++; $display("FAIL async_rst got dir=%0d cnt=%0d empty=%0b full=%0b chg=%0b drop=%0b",
                         dir_out, cnt_out, empty_out, full_out, dir_chg_out, drop_out);
    end
    do_reset();
  endtask

  task automatic test_random();
    bit vld, mv, clr;
    logic [1:0] d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      vld = ($urandom_range(0, 9) < 6);
      mv  = ($urandom_range(0, 9) < 3);
      clr = ($urandom_range(0, 49) == 0);
      d   = 2'($urandom_range(0, 3));
      step(vld, d, mv, clr);
      checks++;
      if (dir_out !== m_dir || dir_chg_out !== exp_chg || drop_out !== exp_drop ||
          cnt_out !== 3'(exp_q.size()) || empty_out !== (exp_q.size() == 0) ||
          full_out !== (exp_q.size() == 4)) begin
        errors++;
        $display("FAIL random_%0d got dir=%0d chg=%0b drop=%0b cnt=%0d emp=%0b full=%0b exp dir=%0d chg=%0b drop=%0b cnt=%0d",
                 i, dir_out, dir_chg_out, drop_out, cnt_out, empty_out, full_out,
                 m_dir, exp_chg, exp_drop, exp_q.size());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    dir_vld_in = 1'b0; mv_in = 1'b0; clr_in = 1'b0; dir_in = 2'd0;
    test_reset();
    test_single_pop();
    test_filter();
    test_fill_drain();
    test_back_to_back();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
